// File: rtl/mc10_clk_pkg.sv
// Shared types and constants for the MC-10 clock/reset block: sequencer states,
// default timing constants and a constant-width helper.
package mc10_clk_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    STABLE   = 2'd1,
    CPU_WAIT = 2'd2,
    RUN      = 2'd3
  } seq_state_e;

  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_CPU_DIV       = 4;
  localparam int DEF_CPU_RST_LAG   = 16;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    while ((32'sd1 << w) < value) w = w + 1;
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mc10_reset_seq_if.sv
// Control/status bundle between the reset sequencer and the rest of the machine.
interface mc10_reset_seq_if;
  import mc10_clk_pkg::*;

  logic       pll_locked;
  logic       soft_rst;
  logic       sys_rst;
  logic       cpu_rst;
  logic       e_clk;
  logic       ce_e_rise;
  logic       ce_e_fall;
  logic [1:0] seq_state;

  modport master (
    output pll_locked, soft_rst,
    input  sys_rst, cpu_rst, e_clk, ce_e_rise, ce_e_fall, seq_state
  );

  modport slave (
    input  pll_locked, soft_rst,
    output sys_rst, cpu_rst, e_clk, ce_e_rise, ce_e_fall, seq_state
  );
endinterface

// File: rtl/mc10_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level, cleared asynchronously.
module mc10_sync_bit (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta_p0;
  logic r_sync_p1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_meta_p0 <= i_d;
      r_sync_p1 <= r_meta_p0;
    end
  end

  assign o_q = r_sync_p1;

endmodule

// File: rtl/mc10_reset_seq.sv
// Ordered reset sequencer (system reset, then CPU reset) and phase-aligned
// E-clock divider for the 6803, running from the PLL output clock.
module mc10_reset_seq
  import mc10_clk_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CPU_DIV       = DEF_CPU_DIV,
  parameter int CPU_RST_LAG   = DEF_CPU_RST_LAG
) (
  input  logic             clk,
  input  logic             rst,
  mc10_reset_seq_if.slave  bus
);

  localparam int CNT_W = clog2w(max2(STABLE_CYCLES, CPU_RST_LAG + 1));
  localparam int PH_W  = clog2w(CPU_DIV);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAG_LAST    = CNT_W'(CPU_RST_LAG - 1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(CPU_DIV - 1);
  localparam logic [PH_W-1:0]  PH_RISE     = PH_W'(CPU_DIV / 2 - 1);
  localparam logic [PH_W-1:0]  PH_HIGH     = PH_W'(CPU_DIV / 2);

  logic             w_locked_s;
  logic             w_abort;
  logic             w_div_on_nxt;
  logic [PH_W-1:0]  w_phase_inc;
  logic [PH_W-1:0]  w_phase_nxt;

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PH_W-1:0]  r_phase;
  logic             r_sys_rst;
  logic             r_cpu_rst;
  logic             r_e_clk;
  logic             r_ce_rise;
  logic             r_ce_fall;

  mc10_sync_bit u_lock_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (bus.pll_locked),
    .o_q   (w_locked_s)
  );

  assign w_abort     = !w_locked_s || bus.soft_rst;
  assign w_phase_inc = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);

  // Divider state for the coming cycle; it only runs in CPU_WAIT/RUN and
  // always enters CPU_WAIT at phase 0 so the CPU starts on a full E period.
  always_comb begin
    w_div_on_nxt = 1'b0;
    w_phase_nxt  = '0;
    if (!w_abort) begin
      case (r_state)
        STABLE: begin
          w_div_on_nxt = (r_cnt == STABLE_LAST);
          w_phase_nxt  = '0;
        end
        CPU_WAIT, RUN: begin
          w_div_on_nxt = 1'b1;
          w_phase_nxt  = w_phase_inc;
        end
        default: begin
          w_div_on_nxt = 1'b0;
          w_phase_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_phase   <= '0;
      r_sys_rst <= 1'b1;
      r_cpu_rst <= 1'b1;
      r_e_clk   <= 1'b0;
      r_ce_rise <= 1'b0;
      r_ce_fall <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_e_clk   <= w_div_on_nxt && (w_phase_nxt >= PH_HIGH);
      r_ce_rise <= w_div_on_nxt && (w_phase_nxt == PH_RISE);
      r_ce_fall <= w_div_on_nxt && (w_phase_nxt == PH_LAST);

      // Abort outranks every transition, including a terminal count.
      if (w_abort) begin
        r_state   <= HOLD;
        r_cnt     <= '0;
        r_sys_rst <= 1'b1;
        r_cpu_rst <= 1'b1;
      end else begin
        case (r_state)
          HOLD: begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end
          STABLE: begin
            if (r_cnt == STABLE_LAST) begin
              r_state   <= CPU_WAIT;
              r_cnt     <= '0;
              r_sys_rst <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          CPU_WAIT: begin
            if (r_ce_fall) begin
              if (r_cnt == LAG_LAST) begin
                r_state   <= RUN;
                r_cnt     <= '0;
                r_cpu_rst <= 1'b0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          RUN: begin
            r_state <= RUN;
          end
          default: begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            r_cpu_rst <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.sys_rst   = r_sys_rst;
  assign bus.cpu_rst   = r_cpu_rst;
  assign bus.e_clk     = r_e_clk;
  assign bus.ce_e_rise = r_ce_rise;
  assign bus.ce_e_fall = r_ce_fall;
  assign bus.seq_state = r_state;

endmodule

// File: tb/tb_mc10_reset_seq.sv
// Directed bench for the MC-10 reset sequencer and E-clock divider at default parameters.
module tb_mc10_reset_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mc10_reset_seq_if bus();

  mc10_reset_seq #(
    .STABLE_CYCLES (1024),
    .CPU_DIV       (4),
    .CPU_RST_LAG   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #140 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until sys_rst drops; n = edges taken, bad = cycles with sys_rst high
  // but cpu_rst low, e_clk high or any divider pulse.
  task automatic count_sys_release(output int n, output int bad, output bit saw_hold);
    n = 0; bad = 0; saw_hold = 0;
    while (bus.sys_rst !== 1'b0 && n < 2000) begin
      step();
      n++;
      if (bus.seq_state === 2'd0) saw_hold = 1;
      if (bus.sys_rst === 1'b1 &&
          (bus.cpu_rst !== 1'b1 || bus.e_clk !== 1'b0 || bus.ce_e_rise !== 1'b0 || bus.ce_e_fall !== 1'b0))
        bad++;
    end
  endtask

  // Steps until cpu_rst drops; falls = ce_e_fall pulses seen while cpu_rst high.
  task automatic run_lag(output int m, output int falls, output int bad);
    m = 0; falls = 0; bad = 0;
    while (bus.cpu_rst !== 1'b0 && m < 200) begin
      step();
      m++;
      if (bus.cpu_rst === 1'b1 && bus.ce_e_fall === 1'b1) falls++;
      if (bus.sys_rst !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.soft_rst = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.sys_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sys_rst: got %b want 1", bus.sys_rst); end
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b want 1", bus.cpu_rst); end
    n_checks++; if (bus.e_clk !== 1'b0) begin n_fail++; $display("FAIL reset_e_clk: got %b want 0", bus.e_clk); end
    n_checks++; if ({bus.ce_e_rise, bus.ce_e_fall} !== 2'b00) begin n_fail++; $display("FAIL reset_ce: got %b want 00", {bus.ce_e_rise, bus.ce_e_fall}); end
    n_checks++; if (bus.seq_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.seq_state); end
  endtask

  task automatic test_powerup();
    int n, bad, m, falls, bad2;
    bit saw_hold;
    bus.pll_locked = 1'b1;
    step();
    rst = 1'b0;
    count_sys_release(n, bad, saw_hold);
    n_checks++; if (n != 1027) begin n_fail++; $display("FAIL powerup_sys_release: got %0d edges want 1027", n); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL powerup_quiet_in_reset: got %0d bad cycles want 0", bad); end
    n_checks++; if (bus.seq_state !== 2'd2) begin n_fail++; $display("FAIL powerup_cpu_wait: got %0d want 2", bus.seq_state); end
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL powerup_cpu_held: got %b want 1", bus.cpu_rst); end
    run_lag(m, falls, bad2);
    n_checks++; if (m != 64) begin n_fail++; $display("FAIL powerup_cpu_lag: got %0d edges want 64", m); end
    n_checks++; if (falls != 16) begin n_fail++; $display("FAIL powerup_lag_falls: got %0d want 16", falls); end
    n_checks++; if (bad2 != 0) begin n_fail++; $display("FAIL powerup_sys_low_in_wait: got %0d bad want 0", bad2); end
    n_checks++; if (bus.seq_state !== 2'd3) begin n_fail++; $display("FAIL powerup_run: got %0d want 3", bus.seq_state); end
    n_checks++; if ({bus.e_clk, bus.ce_e_rise, bus.ce_e_fall} !== 3'b000) begin n_fail++; $display("FAIL powerup_phase0: got %b want 000", {bus.e_clk, bus.ce_e_rise, bus.ce_e_fall}); end
  endtask

  task automatic test_divider();
    logic [3:0] e_pat, r_pat, f_pat;
    e_pat = 4'b1100;
    r_pat = 4'b0010;
    f_pat = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (bus.e_clk !== e_pat[i % 4]) begin n_fail++; $display("FAIL div_e_clk[%0d]: got %b want %b", i, bus.e_clk, e_pat[i % 4]); end
      n_checks++; if (bus.ce_e_rise !== r_pat[i % 4]) begin n_fail++; $display("FAIL div_rise[%0d]: got %b want %b", i, bus.ce_e_rise, r_pat[i % 4]); end
      n_checks++; if (bus.ce_e_fall !== f_pat[i % 4]) begin n_fail++; $display("FAIL div_fall[%0d]: got %b want %b", i, bus.ce_e_fall, f_pat[i % 4]); end
      step();
    end
  endtask

  task automatic test_lock_loss_stable();
    int n, bad, m, falls, bad2, sys_bad;
    bit saw_hold, saw_hold2;
    bus.pll_locked = 1'b0;
    repeat (4) step();
    n_checks++; if (bus.seq_state !== 2'd0 || bus.sys_rst !== 1'b1) begin n_fail++; $display("FAIL lock_drop_hold: got state %0d sys_rst %b want 0/1", bus.seq_state, bus.sys_rst); end
    bus.pll_locked = 1'b1;
    repeat (503) step();
    n_checks++; if (bus.seq_state !== 2'd1) begin n_fail++; $display("FAIL stable_mid: got %0d want 1", bus.seq_state); end
    bus.pll_locked = 1'b0;
    saw_hold = 0; sys_bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.seq_state === 2'd0) saw_hold = 1;
      if (bus.sys_rst !== 1'b1) sys_bad++;
    end
    bus.pll_locked = 1'b1;
    count_sys_release(n, bad, saw_hold2);
    n_checks++; if (!(saw_hold || saw_hold2)) begin n_fail++; $display("FAIL glitch_hold: got no HOLD want HOLD"); end
    n_checks++; if (sys_bad != 0 || bad != 0) begin n_fail++; $display("FAIL glitch_sys_rst: got %0d/%0d bad want 0", sys_bad, bad); end
    n_checks++; if (n != 1027) begin n_fail++; $display("FAIL glitch_release: got %0d edges want 1027", n); end
    run_lag(m, falls, bad2);
    n_checks++; if (m != 64) begin n_fail++; $display("FAIL glitch_cpu_lag: got %0d want 64", m); end
  endtask

  task automatic test_soft_rst();
    int k, n, bad;
    bit saw_hold;
    k = 0;
    while (bus.e_clk !== 1'b1 && k < 10) begin step(); k++; end
    n_checks++; if (bus.e_clk !== 1'b1) begin n_fail++; $display("FAIL soft_pre_e_clk: got %b want 1", bus.e_clk); end
    bus.soft_rst = 1'b1;
    step();
    bus.soft_rst = 1'b0;
    n_checks++; if (bus.sys_rst !== 1'b1) begin n_fail++; $display("FAIL soft_sys_rst: got %b want 1", bus.sys_rst); end
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL soft_cpu_rst: got %b want 1", bus.cpu_rst); end
    n_checks++; if (bus.e_clk !== 1'b0) begin n_fail++; $display("FAIL soft_e_clk: got %b want 0", bus.e_clk); end
    n_checks++; if (bus.seq_state !== 2'd0) begin n_fail++; $display("FAIL soft_state: got %0d want 0", bus.seq_state); end
    count_sys_release(n, bad, saw_hold);
    n_checks++; if (n != 1025) begin n_fail++; $display("FAIL soft_release: got %0d edges want 1025", n); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL soft_quiet: got %0d bad want 0", bad); end
  endtask

  task automatic test_lock_loss_cpu_wait();
    int k, falls, n, bad, m, falls2, bad2, cpu_bad;
    bit saw_hold;
    k = 0; falls = 0;
    while (falls < 10 && k < 200) begin
      step(); k++;
      if (bus.ce_e_fall === 1'b1) falls++;
    end
    n_checks++; if (falls != 10 || bus.seq_state !== 2'd2) begin n_fail++; $display("FAIL wait_ten_falls: got %0d falls state %0d want 10/2", falls, bus.seq_state); end
    bus.pll_locked = 1'b0;
    k = 0; cpu_bad = 0;
    while (bus.sys_rst !== 1'b1 && k < 10) begin
      step(); k++;
      if (bus.cpu_rst !== 1'b1) cpu_bad++;
    end
    n_checks++; if (bus.sys_rst !== 1'b1) begin n_fail++; $display("FAIL wait_abort_sys_rst: got %b want 1", bus.sys_rst); end
    n_checks++; if (cpu_bad != 0 || bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL wait_abort_cpu_rst: got %0d low cycles want 0", cpu_bad); end
    bus.pll_locked = 1'b1;
    count_sys_release(n, bad, saw_hold);
    n_checks++; if (n != 1027) begin n_fail++; $display("FAIL wait_relock_release: got %0d edges want 1027", n); end
    run_lag(m, falls2, bad2);
    n_checks++; if (m != 64 || falls2 != 16) begin n_fail++; $display("FAIL wait_lag_restart: got %0d edges %0d falls want 64/16", m, falls2); end
  endtask

  task automatic test_async_rst();
    int k;
    k = 0;
    while (bus.e_clk !== 1'b1 && k < 10) begin step(); k++; end
    #60;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.sys_rst !== 1'b1) begin n_fail++; $display("FAIL async_sys_rst: got %b want 1", bus.sys_rst); end
    n_checks++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL async_cpu_rst: got %b want 1", bus.cpu_rst); end
    n_checks++; if (bus.e_clk !== 1'b0) begin n_fail++; $display("FAIL async_e_clk: got %b want 0", bus.e_clk); end
    n_checks++; if ({bus.ce_e_rise, bus.ce_e_fall} !== 2'b00) begin n_fail++; $display("FAIL async_ce: got %b want 00", {bus.ce_e_rise, bus.ce_e_fall}); end
    n_checks++; if (bus.seq_state !== 2'd0) begin n_fail++; $display("FAIL async_state: got %0d want 0", bus.seq_state); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_abort_at_terminal();
    int n, bad;
    bit saw_hold;
    repeat (1026) step();
    n_checks++; if (bus.seq_state !== 2'd1 || bus.sys_rst !== 1'b1) begin n_fail++; $display("FAIL term_pre: got state %0d sys_rst %b want 1/1", bus.seq_state, bus.sys_rst); end
    bus.soft_rst = 1'b1;
    step();
    bus.soft_rst = 1'b0;
    n_checks++; if (bus.seq_state !== 2'd0 || bus.sys_rst !== 1'b1) begin n_fail++; $display("FAIL term_abort_wins: got state %0d sys_rst %b want 0/1", bus.seq_state, bus.sys_rst); end
    count_sys_release(n, bad, saw_hold);
    n_checks++; if (n != 1025) begin n_fail++; $display("FAIL term_release: got %0d edges want 1025", n); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_powerup();
    test_divider();
    test_lock_loss_stable();
    test_soft_rst();
    test_lock_loss_cpu_wait();
    test_async_rst();
    test_abort_at_terminal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc10_reset_seq.md
Name: mc10_reset_seq

Overview:
- Sits directly downstream of the system PLL, clocked from its 3.579 MHz output.
- Consumes the PLL's asynchronous lock indication and a front-end soft-reset request.
- Produces an ordered reset sequence: system reset first, then CPU reset, with synchronous deassertion of both.
- Generates the phase-aligned E-clock level and clock-enable pulses (clk/4 ≈ 0.895 MHz) for the 6803 CPU; the 6847 VDG runs at the full clk rate.

Parameters:
- STABLE_CYCLES, 1024: clk cycles with lock continuously held before sys_rst is released. Must be ≥2.
- CPU_DIV, 4: clk cycles per E period. Must be even and ≥2.
- CPU_RST_LAG, 16: E periods between sys_rst release and cpu_rst release. Must be ≥1.

Ports:
- clk  in  1  PLL 3.579 MHz output clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to clk.
- soft_rst  in  1  synchronous level; held high = hold the machine in reset.
- sys_rst  out  1  active-high system reset, registered.
- cpu_rst  out  1  active-high CPU reset, registered.
- e_clk  out  1  E-clock level, registered.
- ce_e_rise  out  1  one-cycle pulse; e_clk rises at the next edge.
- ce_e_fall  out  1  one-cycle pulse; e_clk falls at the next edge.
- seq_state  out  2  current FSM state, for debug/OSD.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=HOLD; all counters and synchronizer flops cleared.
  - sys_rst=1, cpu_rst=1, e_clk=0, ce_e_rise=0, ce_e_fall=0, seq_state=0.
- Lock synchronization: pll_locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). No other input is synchronized.
- abort = !locked_s | soft_rst. It is evaluated in every state and has priority over all transitions: next state is HOLD. sys_rst, cpu_rst, e_clk and phase are restored to their reset values at the next edge.
- FSM encoding: HOLD=0, STABLE=1, CPU_WAIT=2, RUN=3.
  - HOLD: cnt=0. Go to STABLE when abort=0.
  - STABLE: cnt increments each cycle.
    - When cnt==STABLE_CYCLES-1, go to CPU_WAIT and clear cnt.
    - sys_rst=0 from the first CPU_WAIT cycle.
  - CPU_WAIT: sys_rst=0, cpu_rst=1, divider running.
    - cnt counts ce_e_fall pulses.
    - At the CPU_RST_LAG-th ce_e_fall, go to RUN; cpu_rst=0 from the first RUN cycle. That cycle is phase 0, the start of a full E period.
  - RUN: terminal while abort=0.
- Divider:
  - phase counter runs 0..CPU_DIV-1 and wraps.
  - It is 0 in HOLD/STABLE, starts at 0 on the first CPU_WAIT cycle, and increments in CPU_WAIT/RUN.
  - ce_e_rise=1 when phase==CPU_DIV/2-1; ce_e_fall=1 when phase==CPU_DIV-1. Both are 0 outside CPU_WAIT/RUN.
  - e_clk is registered: 1 during phases CPU_DIV/2..CPU_DIV-1, else 0.
  - The divider never free-runs in reset states, so the CPU always starts phase-aligned.
- Counter width: cnt is clog2(max(STABLE_CYCLES, CPU_RST_LAG+1)) bits and never wraps; the terminal compare precedes any increment.
- Boundary conditions:
  - A lock glitch of any length that reaches locked_s restarts the full STABLE count.
  - A glitch shorter than one clk period may be filtered by the synchronizer; this is acceptable.
  - soft_rst held high keeps HOLD indefinitely. Release follows the same timing as a lock event, minus the 2-cycle synchronizer latency.
  - Simultaneous abort and terminal count: abort wins.
  - rst asserted mid-sequence: immediate asynchronous return to reset values. No partial state survives.
  - Invariant: cpu_rst==1 whenever sys_rst==1.

Decomposition:
- Package mc10_clk_pkg: state enum type (HOLD/STABLE/CPU_WAIT/RUN), the clog2 width function, and default constants for STABLE_CYCLES, CPU_DIV and CPU_RST_LAG.
- One sub-module, mc10_sync_bit: 2-flop synchronizer with asynchronous active-high clear. It is reused for other async inputs in the codebase.

Test Plan:
- Power-up with defaults: rst 1→0, pll_locked=1 sampled at edge 0.
  - sys_rst falls after edge 1027 (2 sync + 1 HOLD + 1024 STABLE).
  - cpu_rst falls exactly 64 cycles later, with phase=0 on that cycle.
- Divider check in RUN with CPU_DIV=4:
  - e_clk pattern is 0,0,1,1 repeating.
  - ce_e_rise is on phase 1 and ce_e_fall on phase 3.
  - Both pulses are exactly 1 cycle; no pulses appear in HOLD/STABLE.
- Lock loss at STABLE cnt=500 (pll_locked low 3 cycles, then high):
  - FSM returns to HOLD.
  - sys_rst stays 1 throughout.
  - Release occurs a full 1027 cycles after re-lock.
- soft_rst pulsed high for 1 cycle in RUN:
  - Next edge: sys_rst=1, cpu_rst=1, e_clk=0, seq_state=0.
  - Re-release after 1025 cycles (no sync latency).
- Lock loss in CPU_WAIT after 10 ce_e_fall pulses: sys_rst reasserts; cpu_rst never deasserted; lag count restarts from 0 on re-lock.
- rst asserted asynchronously mid-RUN, between clk edges: all outputs take reset values without waiting for a clk edge.
